xtal_osc_ctrl: RTL and testbench
================================

# xtal_osc_ctrl

Startup sequencer and frequency monitor for the 3.3 V crystal oscillator macro. It drives the oscillator enable and waits a fixed settling time. It then counts oscillator clock edges against a fixed window of the always-running reference clock, and declares the crystal good only when the count is in range. It retries startup a bounded number of times, and keeps monitoring in run mode so downstream clock-select logic can fall back when the crystal stops.

## Interface
- STARTUP_CYCLES, 4096: reference-clock cycles `OSC_EN` is held before each measurement (≥ 2).
- WINDOW, 256: reference-clock cycles per measurement window (≥ 2, ≤ 65535).
- MIN_EDGES, 32: lowest accepted rising-edge count per window.
- MAX_EDGES, 96: highest accepted rising-edge count per window (MIN_EDGES ≤ MAX_EDGES ≤ 254).
- RETRIES, 3: total startup attempts before failure (≥ 1, ≤ 7).

Ports:
- CLK  in  1  reference clock (internal RC). All logic is in this domain.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  software request to run the crystal (synchronous to `CLK`).
- XCLK  in  1  oscillator `CLK` output. Asynchronous to `CLK`.
- OSC_EN  out  1  drives the oscillator `EN`.
- XTAL_GOOD  out  1  crystal is running within range.
- FAIL  out  1  startup abandoned after RETRIES attempts.
- EDGE_COUNT  out  8  edge count from the last completed window.
- STATE  out  3  current state encoding (debug).

## Operation
- XCLK path: two-flop synchronizer `s1`→`s2`, then an edge flop `s3`. Edge pulse = `s2 & ~s3`. An XCLK rising edge produces a pulse 2–3 CLK cycles later.
- Edge counter: 8 bits, saturates at 255 and never wraps. It clears at the start of every window.
- States (`STATE` encoding): OFF=0, STARTUP=1, MEASURE=2, RUN=3, FAILED=4. Encodings 5–7 return to OFF.
- OFF:
  - `OSC_EN`=0, `XTAL_GOOD`=0, `FAIL`=0.
  - `ENABLE`=1 → STARTUP. The attempt counter is cleared and the timer is cleared.
- STARTUP:
  - `OSC_EN`=1.
  - The timer counts up. After exactly STARTUP_CYCLES cycles in the state → MEASURE, with the timer and edge counter cleared.
- MEASURE:
  - `OSC_EN`=1. Count edge pulses for exactly WINDOW cycles.
  - On the last window cycle, the final count includes a pulse arriving in that cycle, and `EDGE_COUNT` loads the final count.
  - In range [MIN_EDGES, MAX_EDGES] → RUN.
  - Out of range: increment the attempt counter.
    - Attempts < RETRIES → STARTUP. `OSC_EN` stays 1 and is not pulsed low.
    - Otherwise → FAILED.
- RUN:
  - `OSC_EN`=1, `XTAL_GOOD`=1.
  - Back-to-back windows run continuously and `EDGE_COUNT` updates at each window end.
  - Out-of-range window → STARTUP, attempt counter cleared, `XTAL_GOOD` low from the next cycle.
- FAILED:
  - `OSC_EN`=0, `FAIL`=1.
  - Held until `ENABLE`=0, then → OFF. `ENABLE` staying high does not restart.
- `ENABLE`=0 in any state → OFF on the next edge. This has priority over every other transition, including a window end in the same cycle. In that case `EDGE_COUNT` is still updated.
- Outputs `OSC_EN`, `XTAL_GOOD` and `FAIL` are registered, decoded from the next state, and glitch-free.

## Timing
- Reset values:
  - state OFF; `OSC_EN`=0, `XTAL_GOOD`=0, `FAIL`=0, `EDGE_COUNT`=0, `STATE`=0.
  - All counters and synchronizer flops 0.
- `ENABLE` rise in cycle n → `OSC_EN`=1 and STATE=1 after edge n+1.
- STARTUP lasts STARTUP_CYCLES cycles; MEASURE lasts WINDOW cycles.
- First `XTAL_GOOD` rise occurs STARTUP_CYCLES + WINDOW + 1 cycles after `ENABLE` is sampled high.
- Reset mid-operation: all outputs drop to reset values immediately, without waiting for a clock edge.
- XCLK is assumed to have high and low phases each ≥ 1 CLK period. Faster inputs undercount, and that is accepted behaviour.

## Test plan
- Nominal: STARTUP_CYCLES=16, WINDOW=256, XCLK period 4 CLK. Raise `ENABLE` → `EDGE_COUNT`=64±1 and `XTAL_GOOD`=1 at cycle 273±1. `FAIL` stays 0.
- Dead crystal: XCLK held 0 → three STARTUP/MEASURE cycles with `EDGE_COUNT`=0. Then `FAIL`=1 and `OSC_EN`=0. Drop `ENABLE` → OFF next cycle.
- Too fast: XCLK period 2 CLK → `EDGE_COUNT`=128 > 96 on every attempt → FAILED.
- Loss in RUN: reach RUN, then stop XCLK → at the next window end `EDGE_COUNT` ≤ 1, `XTAL_GOOD`=0 on the next cycle, STATE=1, `OSC_EN` remains 1.
- Abort: deassert `ENABLE` at cycle 5 of STARTUP → STATE=0 and `OSC_EN`=0 on the next edge. Re-enable → full STARTUP duration restarts.
- Reset mid-MEASURE: assert `RST` between clock edges → all outputs 0 immediately. After release with `ENABLE`=1, the sequence restarts from OFF → STARTUP.

Source files
------------

// File: rtl/xtal_osc_ctrl.sv
// Crystal oscillator startup sequencer and frequency monitor; XCLK edges are counted
// against fixed windows of the reference clock, with bounded retries and run-mode loss detection.
module xtal_osc_ctrl #(
  parameter int STARTUP_CYCLES = 4096,
  parameter int WINDOW         = 256,
  parameter int MIN_EDGES      = 32,
  parameter int MAX_EDGES      = 96,
  parameter int RETRIES        = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       XCLK,
  output logic       OSC_EN,
  output logic       XTAL_GOOD,
  output logic       FAIL,
  output logic [7:0] EDGE_COUNT,
  output logic [2:0] STATE
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_STARTUP = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_FAILED  = 3'd4;

  // One timer serves both the settling period and the measurement window.
  localparam int TMAX = (STARTUP_CYCLES > WINDOW) ? STARTUP_CYCLES : WINDOW;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] STARTUP_LAST = TW'(STARTUP_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_LAST  = TW'(WINDOW - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [7:0]    MIN_CNT      = 8'(MIN_EDGES);
  localparam logic [7:0]    MAX_CNT      = 8'(MAX_EDGES);
  localparam logic [2:0]    RETRY_LIM    = 3'(RETRIES);

  logic          s1;
  logic          s2;
  logic          s3;
  logic          edge_pulse;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [7:0]    edge_cnt;
  logic [7:0]    edge_cnt_nxt;
  logic [7:0]    final_cnt;
  logic [7:0]    edge_count_nxt;
  logic [2:0]    attempts;
  logic [2:0]    attempts_nxt;
  logic          window_end;
  logic          in_range;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= XCLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

  // Count including this cycle's pulse, so the last window cycle is never lost.
  assign final_cnt  = (edge_cnt == 8'hFF) ? 8'hFF : edge_cnt + {7'd0, edge_pulse};
  assign in_range   = (final_cnt >= MIN_CNT) && (final_cnt <= MAX_CNT);
  assign window_end = ((state == ST_MEASURE) || (state == ST_RUN)) && (timer == WINDOW_LAST);

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    edge_cnt_nxt   = edge_cnt;
    attempts_nxt   = attempts;
    edge_count_nxt = EDGE_COUNT;

    case (state)
      ST_OFF: begin
        if (ENABLE) begin
          state_nxt    = ST_STARTUP;
          timer_nxt    = '0;
          attempts_nxt = '0;
        end
      end
      ST_STARTUP: begin
        if (timer == STARTUP_LAST) begin
          state_nxt    = ST_MEASURE;
          timer_nxt    = '0;
          edge_cnt_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      ST_MEASURE, ST_RUN: begin
        edge_cnt_nxt = final_cnt;
        timer_nxt    = timer + TIMER_ONE;
        if (window_end) begin
          edge_count_nxt = final_cnt;
          edge_cnt_nxt   = '0;
          timer_nxt      = '0;
          if (in_range) begin
            state_nxt = ST_RUN;
          end else if (state == ST_RUN) begin
            // Lost crystal in run mode gets a fresh set of attempts.
            state_nxt    = ST_STARTUP;
            attempts_nxt = '0;
          end else begin
            attempts_nxt = attempts + 3'd1;
            state_nxt    = (attempts_nxt < RETRY_LIM) ? ST_STARTUP : ST_FAILED;
          end
        end
      end
      ST_FAILED: begin
        state_nxt = ST_FAILED;
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase

    // Dropping ENABLE wins over every other transition; EDGE_COUNT still captures a window end.
    if (!ENABLE) begin
      state_nxt = ST_OFF;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_OFF;
      timer      <= '0;
      edge_cnt   <= '0;
      attempts   <= '0;
      EDGE_COUNT <= '0;
      OSC_EN     <= 1'b0;
      XTAL_GOOD  <= 1'b0;
      FAIL       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      edge_cnt   <= edge_cnt_nxt;
      attempts   <= attempts_nxt;
      EDGE_COUNT <= edge_count_nxt;
      OSC_EN     <= (state_nxt == ST_STARTUP) || (state_nxt == ST_MEASURE) || (state_nxt == ST_RUN);
      XTAL_GOOD  <= (state_nxt == ST_RUN);
      FAIL       <= (state_nxt == ST_FAILED);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_xtal_osc_ctrl.sv
// Bench for xtal_osc_ctrl: directed scenarios plus a per-cycle reference model.
module tb_xtal_osc_ctrl;
  localparam int S    = 16;
  localparam int W    = 256;
  localparam int MINE = 32;
  localparam int MAXE = 96;
  localparam int R    = 3;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic       xclk   = 1'b0;
  logic       osc_en;
  logic       xtal_good;
  logic       fail;
  logic [7:0] edge_count;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;
  int xper   = 4;
  int ph     = 0;
  bit chk_on = 0;

  // Reference model: phase (0 off,1 startup,2 measure,3 run,4 failed), time spent, rises seen.
  int m_state = 0, m_elapsed = 0, m_tally = 0, m_att = 0, m_ecount = 0;
  int x1 = 0, x2 = 0, x3 = 0;

  xtal_osc_ctrl #(
    .STARTUP_CYCLES(S), .WINDOW(W), .MIN_EDGES(MINE), .MAX_EDGES(MAXE), .RETRIES(R)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .XCLK(xclk),
    .OSC_EN(osc_en), .XTAL_GOOD(xtal_good), .FAIL(fail),
    .EDGE_COUNT(edge_count), .STATE(state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (xper == 0) xclk = 1'b0;
      else begin
        ph++;
        xclk = ((ph % xper) < (xper / 2));
      end
    end
  end

  task automatic model_step();
    int rise;
    int cnt;
    rise = (x2 == 1 && x3 == 0) ? 1 : 0;
    x3 = x2; x2 = x1; x1 = int'(xclk);
    case (m_state)
      0: if (enable) begin m_state = 1; m_elapsed = 0; m_att = 0; end
      1: begin
        m_elapsed++;
        if (m_elapsed == S) begin m_state = 2; m_elapsed = 0; m_tally = 0; end
      end
      2, 3: begin
        m_tally += rise;
        m_elapsed++;
        if (m_elapsed == W) begin
          cnt = (m_tally > 255) ? 255 : m_tally;
          m_ecount = cnt; m_tally = 0; m_elapsed = 0;
          if (cnt >= MINE && cnt <= MAXE) m_state = 3;
          else if (m_state == 3) begin m_state = 1; m_att = 0; end
          else begin m_att++; m_state = (m_att < R) ? 1 : 4; end
        end
      end
      default: ;
    endcase
    if (!enable) m_state = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_elapsed = 0; m_tally = 0; m_att = 0; m_ecount = 0;
      x1 = 0; x2 = 0; x3 = 0;
    end else begin
      model_step();
    end
  end

  initial begin
    int e_osc, e_good, e_fail;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        e_osc  = (m_state >= 1 && m_state <= 3) ? 1 : 0;
        e_good = (m_state == 3) ? 1 : 0;
        e_fail = (m_state == 4) ? 1 : 0;
        total++;
        if (int'(state) == m_state && int'(osc_en) == e_osc && int'(xtal_good) == e_good &&
            int'(fail) == e_fail && int'(edge_count) == m_ecount)
          passed++;
        else
          $display("FAIL model_cycle t=%0t: got state=%0d osc_en=%0d good=%0d fail=%0d count=%0d, expected %0d %0d %0d %0d %0d",
                   $time, state, osc_en, xtal_good, fail, edge_count, m_state, e_osc, e_good, e_fail, m_ecount);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return xtal_good === 1'b1;
      1:       return fail === 1'b1;
      2:       return xtal_good === 1'b0;
      default: return state === 3'd2;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(cond(which)), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_osc_en", int'(osc_en), 0);
    chk("reset_good", int'(xtal_good), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_edge_count", int'(edge_count), 0);

    // Nominal startup with XCLK period 4
    xper = 4;
    repeat (8) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("enable_state", int'(state), 1);
    chk("enable_osc_en", int'(osc_en), 1);
    wait_for(0, 400, "nominal_timeout", n);
    chk("nominal_good_latency", n + 1, 273);
    chk("nominal_edge_count", int'(edge_count), 64);
    chk("nominal_fail", int'(fail), 0);

    // Reset asserted between edges while measuring
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_for(3, 40, "measure_timeout", n);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_osc_en", int'(osc_en), 0);
    chk("rst_good", int'(xtal_good), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_edge_count", int'(edge_count), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_restart_state", int'(state), 1);
    chk("rst_restart_osc_en", int'(osc_en), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_state", int'(state), 0);

    // Dead crystal
    xper = 0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_for(1, 1000, "dead_timeout", n);
    chk("dead_fail_latency", n, 817);
    chk("dead_edge_count", int'(edge_count), 0);
    chk("dead_osc_en", int'(osc_en), 0);
    chk("dead_state", int'(state), 4);
    repeat (10) @(negedge clk);
    chk("failed_hold_state", int'(state), 4);
    enable = 1'b0;
    @(negedge clk);
    chk("failed_to_off_state", int'(state), 0);
    chk("failed_to_off_fail", int'(fail), 0);

    // Crystal too fast
    xper = 2;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_for(1, 1000, "fast_timeout", n);
    chk("fast_fail_latency", n, 817);
    chk("fast_edge_count", int'(edge_count), 128);
    enable = 1'b0;
    @(negedge clk);

    // Abort during startup, then a full restart
    xper = 4;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_pre_state", int'(state), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_state", int'(state), 0);
    chk("abort_osc_en", int'(osc_en), 0);
    enable = 1'b1;
    wait_for(0, 400, "abort_restart_timeout", n);
    chk("abort_restart_latency", n, 273);

    // Loss of crystal while running
    xper = 0;
    wait_for(2, 300, "loss_timeout", n);
    chk("loss_latency", n, 256);
    chk("loss_edge_count_low", int'(edge_count <= 8'd1), 1);
    chk("loss_state", int'(state), 1);
    chk("loss_osc_en", int'(osc_en), 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
